debounce_en_gen: RTL and testbench
==================================

// Module: debounce_en_gen
// PURPOSE
//  Upstream stage for the enable-gated D flip-flop (d_ff_en_2s).
//  Turns a raw async level (button/switch) into two clean signals: db_level, and
//  one-cycle rise/fall ticks. rise_tick drives the flip-flop's en input.
//  Chain: 2-FF synchronizer -> counter-qualified 4-state FSM -> registered outputs.
// PARAMETERS
//  STABLE_CYCLES  1_000_000  synced input must hold this many clk cycles to be accepted (>=2; tb uses 4)
//  CNT_W          $clog2(STABLE_CYCLES)  counter width (localparam, derived)
// PORTS
//  clk        in   1  system clock; all logic on posedge
//  rst        in   1  reset, synchronous, active-low
//  sw         in   1  raw asynchronous input
//  db_level   out  1  debounced level (registered)
//  rise_tick  out  1  one-cycle pulse on accepted 0->1 (registered); feeds en
//  fall_tick  out  1  one-cycle pulse on accepted 1->0 (registered)
// BEHAVIOUR
//  Reset (rst==0 sampled at posedge): s1=s2=0, state=ZERO, cnt=0;
//   db_level=0, rise_tick=0, fall_tick=0. Reset overrides all other activity,
//   including mid-WAIT; no tick is ever emitted in the cycle reset is applied.
//  Sync: s1<=sw, s2<=s1. Only s2 is used by the FSM.
//  FSM, evaluated each posedge:
//   ZERO : s2==1 -> WAIT1, cnt<=0; else stay.
//   WAIT1: s2==0 -> ZERO, cnt<=0 (glitch rejected, no tick);
//          else if cnt==STABLE_CYCLES-1 -> ONE, db_level<=1, rise_tick<=1;
//          else cnt<=cnt+1.
//   ONE  : s2==0 -> WAIT0, cnt<=0; else stay.
//   WAIT0: s2==1 -> ONE, cnt<=0 (no tick);
//          else if cnt==STABLE_CYCLES-1 -> ZERO, db_level<=0, fall_tick<=1;
//          else cnt<=cnt+1.
//  Ticks: default 0 every cycle. Each is high for exactly one cycle, only on
//   the transition edge. rise_tick and fall_tick are never high together.
//  db_level changes only on WAIT1->ONE and WAIT0->ZERO. It holds its value
//   through WAIT states.
//  Latency: sw goes 1 just before posedge k and stays stable. s2=1 after k+1;
//   WAIT1 entered at k+2; db_level=1 and rise_tick=1 after posedge
//   k+2+STABLE_CYCLES. Falling direction is symmetric.
//  A bounce shorter than STABLE_CYCLES synced cycles produces no output change.
//   Each bounce restarts the count from 0.
//  cnt never exceeds STABLE_CYCLES-1, so no wrap. Unused state encodings -> ZERO.
// TESTING  (STABLE_CYCLES=4, T=20ns; drive sw at negedge)
//  1 Reset: rst=0 for 2 cycles with sw=1 -> db_level=0, both ticks 0 during
//    reset; after rst=1, rise_tick pulses 1 cycle at posedge 7 after release.
//  2 Clean press: sw 0->1 at negedge before posedge k -> db_level=1 and
//    rise_tick=1 exactly after posedge k+6; rise_tick=0 after k+7.
//  3 Bounce: sw=1 for 2 cycles, 0 for 1, 1 for 3, 0 -> db_level stays 0;
//    rise_tick and fall_tick never asserted.
//  4 Release: from ONE, sw 1->0 held -> fall_tick one cycle 7 posedges later;
//    db_level=0 from the same edge.
//  5 Mid-WAIT reset: sw=1, rst=0 at the cycle WAIT1 has cnt=2 -> state ZERO,
//    outputs 0; with sw still 1 after release, the full 7-edge latency restarts.
//  6 Chain check: rise_tick -> en of d_ff_en_2s with d=1 -> q_en goes 1 only
//    on the posedge after the tick; q_en is unchanged by sw bounces.

Source files
------------

// File: rtl/debounce_en_gen.sv
// debounce_en_gen
//   Cleans a raw asynchronous level (button or switch) for the enable-gated
//   flip-flop stage. A two-flop synchronizer feeds a counter-qualified
//   four-state FSM. The synchronized level must hold for STABLE_CYCLES clocks
//   before it is accepted. All outputs are registered.
//
// Ports
//   clk        in  system clock, all logic on posedge
//   rst        in  synchronous reset, active low
//   sw         in  raw asynchronous input
//   db_level   out debounced level
//   rise_tick  out one-cycle pulse on an accepted 0->1 (drives the flop's en)
//   fall_tick  out one-cycle pulse on an accepted 1->0
module debounce_en_gen #(
    parameter int unsigned STABLE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic sw,
    output logic db_level,
    output logic rise_tick,
    output logic fall_tick
);

    localparam int unsigned      CNT_W   = $clog2(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ZERO  = 2'd0,
        WAIT1 = 2'd1,
        ONE   = 2'd2,
        WAIT0 = 2'd3
    } state_t;

    logic             s1_q, s2_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             db_q, db_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= ZERO;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= sw;
            s2_q    <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    // The counter only advances while the synced level differs from db_level;
    // any reversal drops back to the settled state with the count cleared, so
    // each bounce restarts qualification from zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ZERO: begin
                if (s2_q) begin
                    state_d = WAIT1;
                    cnt_d   = '0;
                end
            end
            WAIT1: begin
                if (!s2_q) begin
                    state_d = ZERO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ONE;
                    db_d    = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ONE: begin
                if (!s2_q) begin
                    state_d = WAIT0;
                    cnt_d   = '0;
                end
            end
            WAIT0: begin
                if (s2_q) begin
                    state_d = ONE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ZERO;
                    db_d    = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ZERO;
                cnt_d   = '0;
            end
        endcase
    end

    assign db_level  = db_q;
    assign rise_tick = rise_q;
    assign fall_tick = fall_q;

endmodule

// File: tb/tb_debounce_en_gen.sv
// tb_debounce_en_gen
//   Bench for debounce_en_gen with STABLE_CYCLES=4, plus a model of the
//   downstream enable flop (d=1, en=rise_tick) to check the chain timing.
//   Each expected vector is {db_level, rise_tick, fall_tick, q_en}.
module tb_debounce_en_gen;

    logic clk = 1'b0;
    logic rst;
    logic sw;
    logic db_level;
    logic rise_tick;
    logic fall_tick;
    logic q_en;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;
    int unsigned cyc     = 0;
    logic [3:0]  exp_q[$];

    always #10 clk = ~clk;

    debounce_en_gen #(.STABLE_CYCLES(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .sw        (sw),
        .db_level  (db_level),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    // Downstream enable flop: q_en <= 1 when en (rise_tick) is high.
    always_ff @(posedge clk) begin
        if (!rst)
            q_en <= 1'b0;
        else if (rise_tick)
            q_en <= 1'b1;
    end

    // Drive n cycles with fixed inputs; push the expected outputs for each
    // of the following posedges.
    task automatic hold(input int unsigned n, input logic sw_v, input logic rst_v,
                        input logic [3:0] e);
        for (int unsigned i = 0; i < n; i++) begin
            sw  = sw_v;
            rst = rst_v;
            exp_q.push_back(e);
            @(negedge clk);
        end
    endtask

    // Monitor: one expected vector per clock after the edge.
    initial begin
        logic [3:0] got;
        logic [3:0] want;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                got  = {db_level, rise_tick, fall_tick, q_en};
                n_total++;
                if (got === want)
                    n_pass++;
                else
                    $display("FAIL out_cyc%0d db/rise/fall/q_en got=%b expected=%b",
                             cyc, got, want);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with sw high: nothing propagates while rst is low.
        hold(2, 1'b1, 1'b0, 4'b0000);
        // Release: rise at posedge 7, q_en one edge later.
        hold(6, 1'b1, 1'b1, 4'b0000);
        hold(1, 1'b1, 1'b1, 4'b1100);
        hold(3, 1'b1, 1'b1, 4'b1001);
        // Release of the switch: fall tick at k+6.
        hold(6, 1'b0, 1'b1, 4'b1001);
        hold(1, 1'b0, 1'b1, 4'b0011);
        hold(4, 1'b0, 1'b1, 4'b0001);
        // Clean press: rise tick at k+6, q_en stays 1.
        hold(6, 1'b1, 1'b1, 4'b0001);
        hold(1, 1'b1, 1'b1, 4'b1101);
        hold(3, 1'b1, 1'b1, 4'b1001);
        // Low pulse of exactly 4 cycles in ONE: one short of acceptance.
        hold(4, 1'b0, 1'b1, 4'b1001);
        hold(8, 1'b1, 1'b1, 4'b1001);
        // Release back to ZERO.
        hold(6, 1'b0, 1'b1, 4'b1001);
        hold(1, 1'b0, 1'b1, 4'b0011);
        hold(3, 1'b0, 1'b1, 4'b0001);
        // Bounce: 1 x2, 0 x1, 1 x3, then 0.
        hold(2, 1'b1, 1'b1, 4'b0001);
        hold(1, 1'b0, 1'b1, 4'b0001);
        hold(3, 1'b1, 1'b1, 4'b0001);
        hold(6, 1'b0, 1'b1, 4'b0001);
        // High pulse of exactly 4 cycles in ZERO: rejected.
        hold(4, 1'b1, 1'b1, 4'b0001);
        hold(8, 1'b0, 1'b1, 4'b0001);
        // Mid-WAIT1 reset at cnt=2, then full latency restarts.
        hold(5, 1'b1, 1'b1, 4'b0001);
        hold(1, 1'b1, 1'b0, 4'b0000);
        hold(6, 1'b1, 1'b1, 4'b0000);
        hold(1, 1'b1, 1'b1, 4'b1100);
        hold(3, 1'b1, 1'b1, 4'b1001);
        // Reset while in ONE: db_level drops with no tick, then re-qualifies.
        hold(1, 1'b1, 1'b0, 4'b0000);
        hold(6, 1'b1, 1'b1, 4'b0000);
        hold(1, 1'b1, 1'b1, 4'b1100);
        hold(2, 1'b1, 1'b1, 4'b1001);

        @(negedge clk);
        n_total++;
        if (exp_q.size() == 0)
            n_pass++;
        else
            $display("FAIL drain pending=%0d expected=0", exp_q.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
